lsu_bus_ctrl: RTL and testbench

LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

---
 rtl/lsu_bus_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl.sv
// LSU-to-external-bus bridge: one outstanding access, alignment/size checks,
// lane-steered stores, extended loads, and an ACKD_n timeout.

module lsu_bus_lane (
  input  logic [1:0] size,
  input  logic [7:0] b_byte,
  input  logic [7:0] h_byte,
  input  logic [7:0] w_byte,
  input  logic [7:0] d_byte,
  output logic [7:0] lane
);
  always_comb begin
    lane = d_byte;
    case (size)
      2'b10:   lane = b_byte;
      2'b01:   lane = h_byte;
      2'b00:   lane = w_byte;
      default: lane = d_byte;
    endcase
  end
endmodule

module lsu_bus_ctrl #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    rsp_err,
  output logic [AW-1:0] DAD,
  output logic          MREQ,
  output logic          WRITE,
  output logic [1:0]    SIZE,
  output logic [DW-1:0] ddt_o,
  output logic          ddt_oe,
  input  logic [DW-1:0] ddt_i,
  input  logic          ACKD_n
);
  localparam int NL = DW / 8;
  localparam int LB = $clog2(NL);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t          state, state_nxt;
  req_t            req_q;
  logic [7:0]      cnt;
  logic [1:0]      err_q;
  logic [DW-1:0]   rdata_q;
  logic            misal, illegal, acc;
  logic [NL-1:0][7:0] steer;

  assign acc = req_valid && (state == IDLE);

  always_comb begin
    illegal = (DW == 32) && (req_size == 2'b11);
    case (req_size)
      2'b01:   misal = req_addr[0];
      2'b00:   misal = |req_addr[1:0];
      2'b11:   misal = |req_addr[2:0];
      default: misal = 1'b0;
    endcase
  end

  // Each byte lane picks its copy of the store operand so narrow data is
  // replicated across every lane of its width.
  for (genvar k = 0; k < NL; k++) begin : g_lane
    lsu_bus_lane u_lane (
      .size  (req_q.size),
      .b_byte(req_q.wdata[7:0]),
      .h_byte(req_q.wdata[8*(k%2) +: 8]),
      .w_byte(req_q.wdata[8*(k%4) +: 8]),
      .d_byte(req_q.wdata[8*k +: 8]),
      .lane  (steer[k])
    );
  end

  // Load extraction: shift the addressed lane down, then extend by shifting
  // it to the top and back with logical or arithmetic right shift.
  logic [DW-1:0]        lane_sh, lane_up, zext, ext;
  logic signed [DW-1:0] sext;
  int                   shamt;

  always_comb begin
    lane_sh = ddt_i >> {req_q.addr[LB-1:0], 3'b000};
    case (req_q.size)
      2'b10:   shamt = DW - 8;
      2'b01:   shamt = DW - 16;
      2'b00:   shamt = DW - 32;
      default: shamt = 0;
    endcase
    lane_up = lane_sh << shamt;
    zext    = lane_up >> shamt;
    sext    = $signed(lane_up) >>> shamt;
    ext     = req_q.uns ? zext : sext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 2'b00;
    rsp_rdata = '0;
    MREQ      = 1'b0;
    WRITE     = 1'b0;
    ddt_oe    = 1'b0;
    DAD       = '0;
    SIZE      = 2'b00;
    ddt_o     = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (illegal || misal) ? RESP : BUS;
      end
      BUS: begin
        MREQ   = 1'b1;
        WRITE  = req_q.we;
        ddt_oe = req_q.we;
        DAD    = req_q.addr;
        SIZE   = req_q.size;
        ddt_o  = steer;
        if (!ACKD_n || cnt == 8'(TIMEOUT)) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      cnt     <= '0;
      err_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          req_q   <= '{we: req_we, size: req_size, uns: req_unsigned,
                       addr: req_addr, wdata: req_wdata};
          cnt     <= 8'd1;
          rdata_q <= '0;
          err_q   <= illegal ? 2'b11 : (misal ? 2'b01 : 2'b00);
        end
        BUS: begin
          // An ack on the final allowed cycle wins over the timeout.
          if (!ACKD_n) begin
            rdata_q <= req_q.we ? '0 : ext;
            err_q   <= 2'b00;
            cnt     <= '0;
          end else if (cnt == 8'(TIMEOUT)) begin
            err_q <= 2'b10;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: rdata_q <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl with a response scoreboard and bus-side checks.

module tb_lsu_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] DAD;
  logic        MREQ, WRITE, ddt_oe, ACKD_n;
  logic [1:0]  SIZE;
  logic [31:0] ddt_o, ddt_i;

  lsu_bus_ctrl #(.DW(32), .AW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .DAD(DAD), .MREQ(MREQ),
    .WRITE(WRITE), .SIZE(SIZE), .ddt_o(ddt_o), .ddt_oe(ddt_oe),
    .ddt_i(ddt_i), .ACKD_n(ACKD_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   mreq_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: counts bus cycles and checks every response against the scoreboard.
  always @(negedge clk) begin
    if (MREQ) mreq_cnt++;
    if (rsp_valid) begin
      compared++;
      if (sbq.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc != e.cyc) begin
          mismatched++;
          $display("FAIL %s: got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                   e.name, rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  end

  task automatic issue(input bit we, input bit [1:0] sz, input bit uns,
                       input bit [31:0] a, input bit [31:0] wd);
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk("ready_before_issue", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // k = edge (counted from acceptance) at which ACKD_n is seen low; 0 = never.
  task automatic xact(input string nm, input bit we, input bit [1:0] sz, input bit uns,
                      input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rd,
                      input int k, input int lat, input bit [31:0] er, input bit [1:0] ee,
                      input int emreq, input bit [31:0] eddt);
    exp_t e;
    mreq_cnt = 0;
    ddt_i = rd;
    issue(we, sz, uns, a, wd);
    e.rdata = er; e.err = ee; e.cyc = cyc + lat; e.name = nm;
    sbq.push_back(e);
    if (emreq > 0) begin
      @(negedge clk);
      chk({nm, "_busctl"}, {req_ready, MREQ, WRITE, ddt_oe, SIZE, DAD}, {1'b0, 1'b1, we, we, sz, a});
      if (we) chk({nm, "_ddt_o"}, ddt_o, eddt);
      if (k > 0) begin
        repeat (k - 1) @(posedge clk);
        #1 ACKD_n = 1'b0;
        @(posedge clk);
        #1 ACKD_n = 1'b1;
      end
    end
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL %s_timeout: got no response expected one within 40 cycles", nm);
      sbq.delete();
    end
    @(negedge clk);
    chk({nm, "_mreq_cycles"}, mreq_cnt, emreq);
    chk({nm, "_ready_after"}, req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; ddt_i = '0; ACKD_n = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("reset_outputs", {req_ready, rsp_valid, rsp_err, MREQ, WRITE, ddt_oe, SIZE},
        {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00});
    chk("reset_buses", {DAD, ddt_o}, 64'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    //   name          we sz    uns addr          wdata         ddt_i         k lat exp_rdata     err   mreq ddt_o
    xact("ld_b_s",     0, 2'b10, 0, 32'h0000_1003, 32'h0,        32'h80FF_FF12, 2, 2, 32'hFFFF_FF80, 2'b00, 2, 32'h0);
    xact("ld_h_u",     0, 2'b01, 1, 32'h0000_1002, 32'h0,        32'hBEEF_1234, 1, 1, 32'h0000_BEEF, 2'b00, 1, 32'h0);
    xact("st_b",       1, 2'b10, 0, 32'h0000_2001, 32'h0000_00A5, 32'h0,        1, 1, 32'h0,        2'b00, 1, 32'hA5A5_A5A5);
    xact("misal_w",    0, 2'b00, 0, 32'h0000_2002, 32'h0,        32'hFFFF_FFFF, 0, 0, 32'h0,        2'b01, 0, 32'h0);
    xact("illegal_sz", 0, 2'b11, 0, 32'h0000_2000, 32'h0,        32'hFFFF_FFFF, 0, 0, 32'h0,        2'b11, 0, 32'h0);
    xact("timeout",    0, 2'b00, 0, 32'h0000_4000, 32'h0,        32'h1234_5678, 0, 4, 32'h0,        2'b10, 4, 32'h0);
    xact("ack_at_to",  0, 2'b00, 0, 32'h0000_4004, 32'h0,        32'h8000_0001, 4, 4, 32'h8000_0001, 2'b00, 4, 32'h0);
    xact("st_h",       1, 2'b01, 0, 32'h0000_2002, 32'h0000_1234, 32'h0,        3, 3, 32'h0,        2'b00, 3, 32'h1234_1234);
    xact("ld_h_s",     0, 2'b01, 0, 32'h0000_1000, 32'h0,        32'h1234_8001, 1, 1, 32'hFFFF_8001, 2'b00, 1, 32'h0);
    xact("misal_h",    0, 2'b01, 0, 32'h0000_1001, 32'h0,        32'h0,        0, 0, 32'h0,        2'b01, 0, 32'h0);
    xact("ld_b_u",     0, 2'b10, 1, 32'h0000_1001, 32'h0,        32'h0000_F000, 1, 1, 32'h0000_00F0, 2'b00, 1, 32'h0);
    xact("st_w",       1, 2'b00, 0, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0,        2, 2, 32'h0,        2'b00, 2, 32'hDEAD_BEEF);

    // Reset in the middle of a bus cycle: bus drops at once, no response follows.
    issue(0, 2'b00, 0, 32'h0000_3000, 32'h0);
    @(negedge clk);
    chk("abort_mreq_before", MREQ, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("abort_bus_idle", {MREQ, WRITE, ddt_oe, SIZE, req_ready}, {1'b0, 1'b0, 1'b0, 2'b00, 1'b1});
    chk("abort_dad", DAD, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);

    xact("after_rst",  0, 2'b00, 0, 32'h0000_5000, 32'h0,        32'h1234_5678, 1, 1, 32'h1234_5678, 2'b00, 1, 32'h0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
